// File: rtl/tpu_ub_pkg.sv
// Shared definitions for the unified-buffer (UB) port.
//   UB_ADDR_W / UB_DATA_W / UB_LEN_W : default geometry of the UB port
//   REQ_HOST / REQ_SA / REQ_VPU      : requester indices on the arbiter
//   ub_burst_t                       : one burst descriptor {we, addr, len}
package tpu_ub_pkg;

    localparam int UB_ADDR_W = 10;
    localparam int UB_DATA_W = 64;
    localparam int UB_LEN_W  = 3;
    localparam int UB_N_REQ  = 3;

    localparam int REQ_HOST = 0;
    localparam int REQ_SA   = 1;
    localparam int REQ_VPU  = 2;

    // len encodes beats-1, so a burst is 1..2^UB_LEN_W beats.
    typedef struct packed {
        logic                 we;
        logic [UB_ADDR_W-1:0] addr;
        logic [UB_LEN_W-1:0]  len;
    } ub_burst_t;

endpackage

// File: rtl/ub_port_arbiter_if.sv
// Bundle of every non-clock signal of the UB port arbiter.
//   req_*   : per-master request side (flattened, master m owns slice m)
//   rsp_*   : read-return side, rsp_rdata shared and qualified by rsp_val
//   ub_*    : the single physical UB access port
//   arb_busy: high while a burst owns the port
// Handshake: a beat of master m transfers in a cycle where req_val[m] and
// req_rdy[m] are both high. req_rdy never depends on anything but the
// current owner, and a master must hold req_val (with stable we/addr/len)
// until it is granted; wdata must be stable while req_val is high.
// Modports: slave = arbiter view, master = environment (masters + UB) view.
interface ub_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int N_REQ  = 3,
    parameter int LEN_W  = 3
);
    logic [N_REQ-1:0]        req_val;
    logic [N_REQ-1:0]        req_rdy;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*LEN_W-1:0]  req_len;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        rsp_val;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    ub_en;
    logic                    ub_we;
    logic [ADDR_W-1:0]       ub_addr;
    logic [DATA_W-1:0]       ub_wdata;
    logic [DATA_W-1:0]       ub_rdata;
    logic                    arb_busy;

    modport slave (
        input  req_val, req_we, req_addr, req_len, req_wdata, ub_rdata,
        output req_rdy, rsp_val, rsp_rdata, ub_en, ub_we, ub_addr, ub_wdata,
               arb_busy
    );

    modport master (
        output req_val, req_we, req_addr, req_len, req_wdata, ub_rdata,
        input  req_rdy, rsp_val, rsp_rdata, ub_en, ub_we, ub_addr, ub_wdata,
               arb_busy
    );
endinterface

// File: rtl/ub_port_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : index searched first; search wraps cyclically
//   grant : one-hot, first requester at or after ptr (zero if none)
//   any   : at least one request present
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             any
);
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        grant = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            // ptr + i < 2N, so one conditional subtract is a full modulo.
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
            idx = sum[PTR_W-1:0];
            if (grant == '0 && req[idx]) grant[idx] = 1'b1;
        end
    end

    assign any = |req;
endmodule

// File: rtl/ub_port_arbiter.sv
// Shares the single UB port between N_REQ masters, round-robin per burst.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ub_port_arbiter_if.slave (request, response and UB signals)
// IDLE arbitrates and latches the winner's burst; BURST issues one UB beat
// per cycle in which the owner holds req_val. UB-side outputs are
// combinational so a beat reaches the UB in the cycle it is accepted.
module ub_port_arbiter
    import tpu_ub_pkg::*;
#(
    parameter int ADDR_W = UB_ADDR_W,
    parameter int DATA_W = UB_DATA_W,
    parameter int N_REQ  = UB_N_REQ,
    parameter int LEN_W  = UB_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    ub_port_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]        state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W:0]    beats_q;
    logic              rsp_pend_q;
    logic [PTR_W-1:0]  rsp_owner_q;

    logic [N_REQ-1:0]  grant;
    logic              any;
    logic [PTR_W-1:0]  grant_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic              own_val;
    logic [DATA_W-1:0] own_wdata;
    logic              in_burst;
    logic              fire;

    rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_rr_pick (
        .req   (bus.req_val),
        .ptr   (ptr_q),
        .grant (grant),
        .any   (any)
    );

    // Demux the winner's descriptor and the owner's live beat signals.
    always_comb begin
        grant_idx = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        own_val   = 1'b0;
        own_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
                sel_we    = bus.req_we[i];
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_len   = bus.req_len[i*LEN_W +: LEN_W];
            end
            if (owner_q == PTR_W'(i)) begin
                own_val   = bus.req_val[i];
                own_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_burst = (state_q == ST_BURST);
    assign fire     = in_burst && own_val;

    always_comb begin
        bus.req_rdy = '0;
        bus.rsp_val = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (in_burst && owner_q == PTR_W'(i)) bus.req_rdy[i] = 1'b1;
            if (rsp_pend_q && rsp_owner_q == PTR_W'(i)) bus.rsp_val[i] = 1'b1;
        end
    end

    // Everything on the UB port is zero outside a firing beat.
    assign bus.ub_en     = fire;
    assign bus.ub_we     = fire && we_q;
    assign bus.ub_addr   = fire ? addr_q : '0;
    assign bus.ub_wdata  = (fire && we_q) ? own_wdata : '0;
    assign bus.arb_busy  = in_burst;
    // The UB already returns registered data one cycle after the beat, which
    // lines up with rsp_pend_q; gating keeps the shared bus quiet otherwise.
    assign bus.rsp_rdata = rsp_pend_q ? bus.ub_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            beats_q     <= '0;
            rsp_pend_q  <= 1'b0;
            rsp_owner_q <= '0;
        end else begin
            // Owner tag travels with the read so the bubble-cycle response
            // cannot be misrouted by the grant made in that same cycle.
            rsp_pend_q <= fire && !we_q;
            if (fire) rsp_owner_q <= owner_q;

            case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        owner_q <= grant_idx;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        beats_q <= (LEN_W+1)'(sel_len) + (LEN_W+1)'(1);
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (fire) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        beats_q <= beats_q - (LEN_W+1)'(1);
                        if (beats_q == (LEN_W+1)'(1)) begin
                            state_q <= ST_IDLE;
                            ptr_q   <= (owner_q == PTR_W'(N_REQ-1)) ? '0
                                     : owner_q + PTR_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ub_port_arbiter.sv
// Bench for ub_port_arbiter: directed bursts, a transaction-level model
// checked every cycle, and literal expectations per scenario.
module tb_ub_port_arbiter;
    import tpu_ub_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    ub_port_arbiter_if #(.ADDR_W(10), .DATA_W(64), .N_REQ(3), .LEN_W(3)) bus ();

    ub_port_arbiter #(.ADDR_W(10), .DATA_W(64), .N_REQ(3), .LEN_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / UB memory model ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (bus.ub_en && !bus.ub_we) bus.ub_rdata <= 64'(bus.ub_addr) + 64'hA000;

    // ---------------- checking helpers ----------------
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        else n_pass++;
    endtask

    function automatic int onehot_idx(logic [2:0] v);
        for (int i = 0; i < 3; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        int          c;
        int          owner;
        logic        we;
        logic [9:0]  addr;
        logic [63:0] wdata;
    } beat_t;
    typedef struct {
        int          c;
        int          idx;
        logic [63:0] data;
    } rsp_t;
    beat_t beat_log[$];
    rsp_t  rsp_log[$];

    // ---------------- transaction-level model ----------------
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    bit          m_we;
    int          m_addrs[$];
    bit          m_rsp_pend;
    int          m_rsp_owner;
    logic [63:0] m_rsp_data;

    always @(negedge clk) begin
        bit          fire;
        logic [2:0]  e_rdy, e_rsp;
        logic [9:0]  e_addr;
        logic [63:0] e_wdata, e_rdata;
        fire    = m_busy && bus.req_val[m_owner];
        e_rdy   = m_busy ? 3'(1 << m_owner) : 3'b000;
        e_addr  = fire ? 10'(m_addrs[0]) : 10'h0;
        e_wdata = (fire && m_we) ? bus.req_wdata[m_owner*64 +: 64] : 64'h0;
        e_rsp   = m_rsp_pend ? 3'(1 << m_rsp_owner) : 3'b000;
        e_rdata = m_rsp_pend ? m_rsp_data : 64'h0;
        if (chk_en) begin
            chk("req_rdy",   64'(bus.req_rdy),   64'(e_rdy));
            chk("ub_en",     64'(bus.ub_en),     64'(fire));
            chk("ub_we",     64'(bus.ub_we),     64'(fire && m_we));
            chk("ub_addr",   64'(bus.ub_addr),   64'(e_addr));
            chk("ub_wdata",  bus.ub_wdata,       e_wdata);
            chk("rsp_val",   64'(bus.rsp_val),   64'(e_rsp));
            chk("rsp_rdata", bus.rsp_rdata,      e_rdata);
            chk("arb_busy",  64'(bus.arb_busy),  64'(m_busy));
            if (bus.ub_en === 1'b1)
                beat_log.push_back('{cyc, onehot_idx(bus.req_rdy), bus.ub_we, bus.ub_addr, bus.ub_wdata});
            if (bus.rsp_val !== 3'b000)
                rsp_log.push_back('{cyc, onehot_idx(bus.rsp_val), bus.rsp_rdata});
        end
        // Advance the model to what must hold after the coming posedge.
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_owner = 0; m_we = 0;
            m_addrs.delete(); m_rsp_pend = 0; m_rsp_owner = 0; m_rsp_data = '0;
        end else begin
            m_rsp_pend = fire && !m_we;
            if (fire) begin
                m_rsp_owner = m_owner;
                m_rsp_data  = 64'(m_addrs[0]) + 64'hA000;
                void'(m_addrs.pop_front());
                if (m_addrs.size() == 0) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % 3;
                end
            end else if (!m_busy && bus.req_val != 3'b000) begin
                for (int k = 0; k < 3; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 3;
                    if (!m_busy && bus.req_val[idx]) begin
                        m_busy  = 1;
                        m_owner = idx;
                        m_we    = bus.req_we[idx];
                        for (int b = 0; b <= int'(bus.req_len[idx*3 +: 3]); b++)
                            m_addrs.push_back((int'(bus.req_addr[idx*10 +: 10]) + b) % 1024);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(int m, ub_burst_t b);
        bus.req_we[m]          = b.we;
        bus.req_addr[m*10 +: 10] = b.addr;
        bus.req_len[m*3 +: 3]  = b.len;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_val = '0;
        step(1);
        rst = 1'b0;
        beat_log.delete();
        rsp_log.delete();
    endtask

    task automatic check_idle_zero(string tag);
        chk({tag, "_busy"},  64'(bus.arb_busy),  64'h0);
        chk({tag, "_rdy"},   64'(bus.req_rdy),   64'h0);
        chk({tag, "_en"},    64'(bus.ub_en),     64'h0);
        chk({tag, "_we"},    64'(bus.ub_we),     64'h0);
        chk({tag, "_addr"},  64'(bus.ub_addr),   64'h0);
        chk({tag, "_wdata"}, bus.ub_wdata,       64'h0);
        chk({tag, "_rspv"},  64'(bus.rsp_val),   64'h0);
        chk({tag, "_rdata"}, bus.rsp_rdata,      64'h0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        bus.req_val   = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;
        step(2);
        rst = 1'b0;
        do_reset();
        chk_en = 1'b1;
        check_idle_zero("reset");

        // Single 8-beat read by VPU.
        set_req(2, '{we: 1'b0, addr: 10'h010, len: 3'd7});
        bus.req_val[2] = 1'b1;
        step(9);
        bus.req_val[2] = 1'b0;
        step(3);
        chk("rd_nbeats", 64'(beat_log.size()), 64'd8);
        chk("rd_nrsp",   64'(rsp_log.size()),  64'd8);
        for (int i = 0; i < 8 && i < beat_log.size() && i < rsp_log.size(); i++) begin
            chk("rd_addr",  64'(beat_log[i].addr),  64'h010 + 64'(i));
            chk("rd_owner", 64'(beat_log[i].owner), 64'd2);
            chk("rd_cyc",   64'(beat_log[i].c - beat_log[0].c), 64'(i));
            chk("rd_ridx",  64'(rsp_log[i].idx),    64'd2);
            chk("rd_rdata", rsp_log[i].data,        64'hA010 + 64'(i));
            chk("rd_rlag",  64'(rsp_log[i].c - beat_log[i].c), 64'd1);
        end

        // Round-robin among three held single-beat writes.
        do_reset();
        for (int m = 0; m < 3; m++) begin
            set_req(m, '{we: 1'b1, addr: 10'(10'h040 + 10'(m * 16)), len: 3'd0});
            bus.req_wdata[m*64 +: 64] = 64'h5A00 + 64'(m);
        end
        bus.req_val = 3'b111;
        step(8);
        bus.req_val = 3'b000;
        step(2);
        chk("rr_n", 64'(beat_log.size()), 64'd4);
        if (beat_log.size() == 4) begin
            chk("rr_o0", 64'(beat_log[0].owner), 64'd0);
            chk("rr_o1", 64'(beat_log[1].owner), 64'd1);
            chk("rr_o2", 64'(beat_log[2].owner), 64'd2);
            chk("rr_o3", 64'(beat_log[3].owner), 64'd0);
            chk("rr_gap", 64'(beat_log[3].c - beat_log[0].c), 64'd6);
            chk("rr_wd1", beat_log[1].wdata, 64'h5A01);
        end

        // Stalled 4-beat write by SA.
        do_reset();
        set_req(1, '{we: 1'b1, addr: 10'h200, len: 3'd3});
        bus.req_wdata[64 +: 64] = 64'h1111_0000;
        bus.req_val[1] = 1'b1;
        step(1);
        step(1);
        bus.req_wdata[64 +: 64] = 64'h1111_0001;
        step(1);
        bus.req_val[1] = 1'b0;
        bus.req_wdata[64 +: 64] = 64'hDEAD_BEEF;
        step(1);
        chk("st_rdy",  64'(bus.req_rdy),  64'b010);
        chk("st_en",   64'(bus.ub_en),    64'd0);
        chk("st_busy", 64'(bus.arb_busy), 64'd1);
        step(1);
        bus.req_val[1] = 1'b1;
        bus.req_wdata[64 +: 64] = 64'h1111_0002;
        step(1);
        bus.req_wdata[64 +: 64] = 64'h1111_0003;
        step(1);
        bus.req_val[1] = 1'b0;
        step(3);
        chk("st_n", 64'(beat_log.size()), 64'd4);
        if (beat_log.size() == 4) begin
            chk("st_wd0", beat_log[0].wdata, 64'h1111_0000);
            chk("st_wd1", beat_log[1].wdata, 64'h1111_0001);
            chk("st_wd2", beat_log[2].wdata, 64'h1111_0002);
            chk("st_wd3", beat_log[3].wdata, 64'h1111_0003);
            chk("st_a3",  64'(beat_log[3].addr), 64'h203);
            chk("st_c2",  64'(beat_log[2].c - beat_log[0].c), 64'd4);
        end
        chk("st_nrsp", 64'(rsp_log.size()), 64'd0);

        // Address wrap.
        do_reset();
        set_req(0, '{we: 1'b0, addr: 10'h3FE, len: 3'd3});
        bus.req_val[0] = 1'b1;
        step(5);
        bus.req_val[0] = 1'b0;
        step(3);
        chk("wr_n", 64'(beat_log.size()), 64'd4);
        if (beat_log.size() == 4 && rsp_log.size() == 4) begin
            chk("wr_a0", 64'(beat_log[0].addr), 64'h3FE);
            chk("wr_a1", 64'(beat_log[1].addr), 64'h3FF);
            chk("wr_a2", 64'(beat_log[2].addr), 64'h000);
            chk("wr_a3", 64'(beat_log[3].addr), 64'h001);
            chk("wr_d2", rsp_log[2].data, 64'hA000);
        end

        // Back-to-back reads from two masters.
        do_reset();
        set_req(0, '{we: 1'b0, addr: 10'h020, len: 3'd0});
        set_req(1, '{we: 1'b0, addr: 10'h030, len: 3'd0});
        bus.req_val = 3'b011;
        step(2);
        bus.req_val[0] = 1'b0;
        step(2);
        bus.req_val[1] = 1'b0;
        step(2);
        chk("bb_n", 64'(rsp_log.size()), 64'd2);
        if (rsp_log.size() == 2 && beat_log.size() == 2) begin
            chk("bb_i0",  64'(rsp_log[0].idx), 64'd0);
            chk("bb_d0",  rsp_log[0].data,     64'hA020);
            chk("bb_i1",  64'(rsp_log[1].idx), 64'd1);
            chk("bb_d1",  rsp_log[1].data,     64'hA030);
            chk("bb_gap", 64'(rsp_log[1].c - rsp_log[0].c), 64'd2);
            chk("bb_bub", 64'(beat_log[1].c - rsp_log[0].c), 64'd1);
        end

        // Reset in the middle of an 8-beat read.
        do_reset();
        set_req(1, '{we: 1'b0, addr: 10'h100, len: 3'd7});
        bus.req_val[1] = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.req_val = 3'b000;
        check_idle_zero("mid_rst");
        beat_log.delete();
        rsp_log.delete();
        set_req(0, '{we: 1'b0, addr: 10'h300, len: 3'd0});
        set_req(1, '{we: 1'b0, addr: 10'h310, len: 3'd0});
        bus.req_val = 3'b011;
        step(2);
        bus.req_val = 3'b000;
        step(3);
        chk("mr_n", 64'(beat_log.size()), 64'd1);
        if (beat_log.size() >= 1) begin
            chk("mr_owner", 64'(beat_log[0].owner), 64'd0);
            chk("mr_addr",  64'(beat_log[0].addr),  64'h300);
        end

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
